load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the byte-addressed little-endian data memory.
- Accepts one load/store request at a time: lb/lbu/lh/lhu/lw/sb/sh/sw.
- Issues only word-aligned accesses to the memory. Sub-word loads are extracted and extended here. Sub-word stores use a read-modify-write sequence.
- Flags misaligned and out-of-range requests without touching memory; the pipeline stalls on req_ready.

Parameters:
MEM_BYTES, 1024, size of the data memory in bytes; a request whose highest byte is at address >= MEM_BYTES is an error.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  zero-extend loads (lbu/lhu); ignored for stores and words
req_addr  input  32  byte address
req_wdata  input  32  store data; low bits used for byte/half
resp_valid  output  1  one-cycle completion pulse
resp_error  output  1  qualifies resp_valid: misaligned, illegal size or out of range
resp_rdata  output  32  extended load data
mem_address  output  32  word-aligned memory address
mem_write_data  output  32  full word to write
mem_read  output  1  memory read enable; the read data is combinational
mem_write  output  1  memory write enable
mem_read_data  input  32  word returned by memory

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except req_ready = 1; captured request registers cleared. Any in-flight operation is abandoned and mem_write drops immediately. No partial write is completed after rst rises.
- Accept: req_valid && req_ready at a rising edge. The unit captures addr, size, write, unsigned and wdata. req_ready is 1 only in IDLE.
- Error check at accept (combinational on the request):
  - size == 3.
  - half with addr[0] = 1.
  - word with addr[1:0] != 0.
  - addr + bytes - 1 >= MEM_BYTES, where bytes = 1, 2 or 4.
  - Any error: next state RESP with error set; no memory access.
- States:
  - IDLE -> (accept) RESP if error; RD if load or sub-word store; WR if word store.
  - RD: mem_read = 1 and mem_address = {addr[31:2], 2'b00}. mem_read_data is registered at the end of RD. Next state is WR for a store, RESP for a load.
  - WR: mem_write = 1 and mem_address is the aligned address. mem_write_data is one of:
    - wdata for a word store;
    - the registered word with lane addr[1:0] replaced by wdata[7:0] (byte store);
    - the registered word with lanes {addr[1],1} and {addr[1],0} replaced by wdata[15:8] and wdata[7:0] (half store).
    - Next state RESP.
  - RESP: resp_valid = 1 for exactly one cycle; resp_error is valid in this cycle. Next state IDLE.
- Latency from accept edge T, in cycles where resp_valid = 1:
  - error: T+1
  - load: T+2
  - word store: T+2
  - byte/half store: T+3
  - Back-to-back accepts are possible in the cycle after RESP.
- Load extraction:
  - byte: lane addr[1:0], lane 0 = bits [7:0].
  - half: bits [15:0] when addr[1] = 0, bits [31:16] when addr[1] = 1.
  - Sign-extend unless req_unsigned = 1. Word loads are passed through unchanged.
- resp_rdata is 0 for stores and errors. It holds its value until the next RESP overwrites it.
- mem_read, mem_write, mem_address and mem_write_data are 0 outside RD/WR.
- mem_read and mem_write are never both 1 in the same cycle.
- Downstream memory drops writes to address 0. Stores to word 0 therefore have no effect in memory; the unit still responds normally.
- req inputs are ignored while req_ready = 0.

Test Plan:
- Word round trip: sw addr 0x10, wdata 0xDEADBEEF; then lw 0x10 -> no error, resp_rdata 0xDEADBEEF. Store resp at T+2 and load resp at T+2; one mem_write cycle with mem_address 0x10.
- Byte store RMW: memory word 0x20 = 0x11223344; sb addr 0x22, wdata 0xAB -> RD then WR with mem_write_data 0x11AB3344, resp at T+3. lb 0x22 -> 0xFFFFFFAB; lbu 0x22 -> 0x000000AB.
- Half store/load: word 0x30 = 0; sh 0x32, wdata 0x8001 -> mem_write_data 0x80010000. lh 0x32 -> 0xFFFF8001; lhu 0x32 -> 0x00008001; lh 0x30 -> 0x00000000.
- Errors: lh 0x41, sw 0x42, size = 3, and lw 0x3FD with MEM_BYTES = 1024 -> each gives resp_valid with resp_error = 1 at T+1, resp_rdata 0, and mem_read = mem_write = 0 throughout.
- Handshake: hold req_valid high with two queued lw requests -> req_ready low from T+1 to RESP; the second request is accepted in the cycle after RESP and its response is not merged with the first.
- Reset mid-op: assert rst low during the WR cycle of an sb -> mem_write falls immediately and the unit returns to IDLE with req_ready = 1. After release, lw of that word returns the pre-store value, i.e. no write was committed.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory port, sub-word extract/extend,
// read-modify-write for sub-word stores, alignment and range checking.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rword_q;
    logic [31:0] rdata_q;

    logic [32:0] last_addr;
    logic [1:0]  last_off;
    logic        req_err;
    logic        accept;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] wr_word;
    logic [31:0] ld_word;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  lo,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [31:0] s;
        logic [15:0] h;
        s = w >> {lo, 3'b000};
        h = lo[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'd0:    load_ext = {{24{s[7] & ~u}}, s[7:0]};
            2'd1:    load_ext = {{16{h[15] & ~u}}, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        last_off = 2'd0;
        unique case (req_size)
            2'd1:    last_off = 2'd1;
            2'd2:    last_off = 2'd3;
            default: last_off = 2'd0;
        endcase
    end

    assign last_addr = {1'b0, req_addr} + {31'd0, last_off};
    assign req_err   = (req_size == 2'd3)
                    || (req_size == 2'd1 && req_addr[0])
                    || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                    || (last_addr >= 33'(MEM_BYTES));
    assign accept    = req_valid && (state_q == IDLE);

    // Sub-word stores merge the replicated store data into the read word.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
        unique case (size_q)
            2'd0: begin
                lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                lane_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata_q;
            end
        endcase
        wr_word = (rword_q & ~lane_mask) | (lane_data & lane_mask);
    end

    assign ld_word = load_ext(mem_read_data, addr_q[1:0], size_q, uns_q);

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && req_size == 2'd2)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[31:2], 2'b00};
                state_d     = write_q ? WR : RESP;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_address    = {addr_q[31:2], 2'b00};
                mem_write_data = wr_word;
                state_d        = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_error = resp_valid && err_q;
    assign resp_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rword_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                write_q <= req_write;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                if (req_err)
                    rdata_q <= 32'd0;
            end
            if (state_q == RD) begin
                rword_q <= mem_read_data;
                if (!write_q)
                    rdata_q <= ld_word;
            end
            if (state_q == WR)
                rdata_q <= 32'd0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests against a
// behavioural word memory, responses checked by a separate monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nacc;
        bit          chk_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem [0:255];
    bit init_done = 1'b0;

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[8]    <= 32'h1122_3344;
            mem[20]   <= 32'hCAFE_F00D;
            init_done <= 1'b1;
        end else if (mem_write && mem_address != 32'd0) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: per-transaction memory activity and response comparison.
    int          acc_cnt = 0;
    bit          both_seen = 1'b0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            acc_cnt   = 0;
            both_seen = 1'b0;
        end else begin
            if (mem_read || mem_write) acc_cnt++;
            if (mem_read && mem_write) both_seen = 1'b1;
            if (mem_write) begin
                last_wa = mem_address;
                last_wd = mem_write_data;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    check("mem_accesses", 32'(acc_cnt), 32'(e.nacc));
                    check("rd_wr_overlap", {31'd0, both_seen}, 32'd0);
                    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
                    if (e.chk_wr) begin
                        check("wr_addr", last_wa, e.waddr);
                        check("wr_data", last_wd, e.wdata);
                    end
                end
                acc_cnt   = 0;
                both_seen = 1'b0;
            end
        end
    end

    function automatic exp_t mk(logic err, logic [31:0] rd, int lat,
                                int nacc, bit chk, logic [31:0] wa,
                                logic [31:0] wd);
        exp_t e;
        e.err = err; e.rdata = rd; e.lat = lat; e.nacc = nacc;
        e.chk_wr = chk; e.waddr = wa; e.wdata = wd; e.acc = 0;
        return e;
    endfunction

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Drives a request and returns just after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d, input exp_t e,
                         input bit push);
        int n = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
            finish_run();
        end
        e.acc = cyc + 1;
        if (push) q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input exp_t e);
        issue(w, sz, u, a, d, e, 1'b1);
        drop();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b1;

        // word round trip
        op(1, 2, 0, 32'h10, 32'hDEAD_BEEF,
           mk(0, 32'h0, 2, 1, 1, 32'h10, 32'hDEAD_BEEF));
        op(0, 2, 0, 32'h10, 32'h0, mk(0, 32'hDEAD_BEEF, 2, 1, 0, 0, 0));

        // byte read-modify-write and byte loads
        op(1, 0, 0, 32'h22, 32'h0000_00AB,
           mk(0, 32'h0, 3, 2, 1, 32'h20, 32'h11AB_3344));
        op(0, 0, 0, 32'h22, 32'h0, mk(0, 32'hFFFF_FFAB, 2, 1, 0, 0, 0));
        op(0, 0, 1, 32'h22, 32'h0, mk(0, 32'h0000_00AB, 2, 1, 0, 0, 0));
        op(0, 0, 0, 32'h23, 32'h0, mk(0, 32'h0000_0011, 2, 1, 0, 0, 0));

        // half store and loads
        op(1, 1, 0, 32'h32, 32'h0000_8001,
           mk(0, 32'h0, 3, 2, 1, 32'h30, 32'h8001_0000));
        op(0, 1, 0, 32'h32, 32'h0, mk(0, 32'hFFFF_8001, 2, 1, 0, 0, 0));
        op(0, 1, 1, 32'h32, 32'h0, mk(0, 32'h0000_8001, 2, 1, 0, 0, 0));
        op(0, 1, 0, 32'h30, 32'h0, mk(0, 32'h0000_0000, 2, 1, 0, 0, 0));

        // errors: no memory access, response at T+1
        op(0, 1, 0, 32'h41, 32'h0, mk(1, 32'h0, 1, 0, 0, 0, 0));
        op(1, 2, 0, 32'h42, 32'h1234, mk(1, 32'h0, 1, 0, 0, 0, 0));
        op(0, 3, 0, 32'h44, 32'h0, mk(1, 32'h0, 1, 0, 0, 0, 0));
        op(0, 2, 0, 32'h3FD, 32'h0, mk(1, 32'h0, 1, 0, 0, 0, 0));
        op(0, 0, 0, 32'h400, 32'h0, mk(1, 32'h0, 1, 0, 0, 0, 0));
        op(1, 1, 0, 32'h3FF, 32'h55, mk(1, 32'h0, 1, 0, 0, 0, 0));

        // range boundary: last word is legal
        op(0, 2, 0, 32'h3FC, 32'h0, mk(0, 32'h0, 2, 1, 0, 0, 0));

        // stores to word 0 are dropped by memory
        op(1, 2, 0, 32'h0, 32'h1234_5678,
           mk(0, 32'h0, 2, 1, 1, 32'h0, 32'h1234_5678));
        op(0, 2, 0, 32'h0, 32'h0, mk(0, 32'h0, 2, 1, 0, 0, 0));

        // back-to-back with req_valid held high
        issue(0, 2, 0, 32'h10, 32'h0,
              mk(0, 32'hDEAD_BEEF, 2, 1, 0, 0, 0), 1'b1);
        issue(0, 2, 0, 32'h20, 32'h0,
              mk(0, 32'h11AB_3344, 2, 1, 0, 0, 0), 1'b1);
        drop();
        repeat (3) @(negedge clk);

        // reset during the write phase of a byte store
        issue(1, 0, 0, 32'h50, 32'h77, mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
        drop();
        @(negedge clk);
        check("wr_phase", {31'd0, mem_write}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_drops_write", {31'd0, mem_write}, 32'd0);
        check("rst_ready_mid", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        op(0, 2, 0, 32'h50, 32'h0, mk(0, 32'hCAFE_F00D, 2, 1, 0, 0, 0));

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
